// File: rtl/bus_ram_responder.sv
// Word-wide RAM target for the request/ready bus: latch a request, wait WAIT_STATES cycles,
// then perform a 32-bit read or write and pulse o_ready (with o_fault on bad addresses).
module bus_ram_responder #(
   parameter int SIZE        = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [31:0] i_address,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_fault
);

   localparam int          IDX_W     = $clog2(SIZE);
   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_WAIT    = 2'd1;
   localparam logic [1:0]  S_ACK     = 2'd2;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
   localparam logic [29:0] SIZE_W    = 30'(SIZE);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             rw_q, rw_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic             enter_ack;
   logic             acc_fault;
   logic [IDX_W-1:0] acc_idx;
   logic             ram_we;

   logic [31:0] ram_q [SIZE] = '{default: 32'h0};

   // Upper address bits are compared in full so aliased out-of-range words fault.
   function automatic logic addr_fault(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr[31:2] >= SIZE_W);
   endfunction

   // Next-state, request latching and the access performed on the edge entering ACK.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
      enter_ack = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_request) begin
               rw_d    = i_rw;
               addr_d  = i_address;
               wdata_d = i_wdata;
               cnt_d   = WAIT_INIT;
               if (WAIT_INIT != 4'd0) begin
                  state_d = S_WAIT;
               end else begin
                  state_d   = S_ACK;
                  enter_ack = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!i_request) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q <= 4'd1) begin
               state_d   = S_ACK;
               cnt_d     = 4'd0;
               enter_ack = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // The _d operands are the fresh inputs from IDLE or the latched copy from WAIT.
      acc_fault = addr_fault(addr_d);
      acc_idx   = addr_d[IDX_W+1:2];
      ram_we    = 1'b0;
      if (enter_ack) begin
         ready_d = 1'b1;
         if (acc_fault) begin
            fault_d = 1'b1;
            rdata_d = 32'h0;
         end else if (rw_d) begin
            ram_we = ~i_reset;
         end else begin
            rdata_d = ram_q[acc_idx];
         end
      end else begin
         ram_we = 1'b0;
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rw_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
      end
   end

   // RAM array keeps its contents across reset.
   always_ff @(posedge i_clock) begin
      if (ram_we) begin
         ram_q[acc_idx] <= wdata_d;
      end
   end

   assign o_rdata = rdata_q;
   assign o_ready = ready_q;
   assign o_fault = fault_q;

endmodule
